// File: rtl/pos_truth_table_sweeper.sv
// Self-test sweeper for the 4-input POS function: drives all 16 vectors, captures f, grades against EXPECTED.
// Optional build macro POS_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module pos_truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [15:0] EXPECTED      = 16'hFA50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        drv_x,
  output logic        drv_y,
  output logic        drv_z,
  output logic        drv_w,
  input  logic        f_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic        pass,
  output logic [4:0]  mismatch_count,
  output logic [3:0]  first_fail_idx
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned MC_W    = 5;
  localparam int unsigned NUM_VEC = 16;

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;

  logic            w_sample;
  logic            w_miss;
  logic            w_last;
  logic            w_stop;
  logic [MC_W-1:0] w_mc_next;

  assign {drv_x, drv_y, drv_z, drv_w} = r_idx;

  assign w_sample  = (r_state == S_SWEEP) && (r_cnt == CNT_W'(SETTLE_CYCLES));
  assign w_miss    = (f_in != EXPECTED[r_idx]);
  assign w_last    = (r_idx == IDX_W'(NUM_VEC - 1));
  assign w_mc_next = mismatch_count + MC_W'(w_miss);

`ifdef POS_STOP_ON_FAIL_EN
  assign w_stop = w_miss;
`else
  assign w_stop = 1'b0;
`endif

  // Sweep control and result capture; done is a single-cycle pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_idx          <= '0;
      r_cnt          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      truth_table    <= '0;
      pass           <= 1'b0;
      mismatch_count <= '0;
      first_fail_idx <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state        <= S_SWEEP;
            busy           <= 1'b1;
            r_idx          <= '0;
            r_cnt          <= '0;
            truth_table    <= '0;
            pass           <= 1'b0;
            mismatch_count <= '0;
            first_fail_idx <= '0;
          end
        end
        S_SWEEP: begin
          if (w_sample) begin
            truth_table[r_idx] <= f_in;
            mismatch_count     <= w_mc_next;
            if (w_miss && (mismatch_count == '0)) begin
              first_fail_idx <= r_idx;
            end
            if (w_last || w_stop) begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (w_mc_next == '0);
              r_idx   <= '0;
              r_cnt   <= '0;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
              r_cnt <= '0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
